// File: rtl/adder8_serial_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder8_serial_scheduler_pkg
// Purpose  : Shared state encodings, requester IDs and sizing helper.
// Revision : 1.0
// ============================================================================
package adder8_serial_scheduler_pkg;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic c_REQ0 = 1'b0;
    localparam logic c_REQ1 = 1'b1;

    // Byte-index counter width; never narrower than one bit.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder8_serial_scheduler_csa.sv
`default_nettype none
// ============================================================================
// Module   : carryselectadder8bit
// Purpose  : 8-bit carry-select adder; upper nibble precomputed for both carries.
// Revision : 1.0
// ============================================================================
module carryselectadder8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] Sum,
    output logic       Cout
);

    logic [4:0] w_lo;
    logic [4:0] w_hi0;
    logic [4:0] w_hi1;

    assign w_lo  = {1'b0, A[3:0]} + {1'b0, B[3:0]} + {4'b0000, Cin};
    assign w_hi0 = {1'b0, A[7:4]} + {1'b0, B[7:4]};
    assign w_hi1 = {1'b0, A[7:4]} + {1'b0, B[7:4]} + 5'd1;

    assign Sum  = {(w_lo[4] ? w_hi1[3:0] : w_hi0[3:0]), w_lo[3:0]};
    assign Cout = w_lo[4] ? w_hi1[4] : w_hi0[4];

endmodule
`default_nettype wire

// File: rtl/adder8_serial_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : adder8_serial_scheduler
// Purpose  : Round-robin shares one 8-bit adder between two multi-byte requesters.
// Revision : 1.0
// ============================================================================
module adder8_serial_scheduler
    import adder8_serial_scheduler_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [8*WORDS-1:0]   req0_a,
    input  logic [8*WORDS-1:0]   req0_b,
    input  logic                 req0_sub,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [8*WORDS-1:0]   req1_a,
    input  logic [8*WORDS-1:0]   req1_b,
    input  logic                 req1_sub,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_id,
    output logic [8*WORDS-1:0]   resp_sum,
    output logic                 resp_cout,
    output logic                 resp_ovf,
    output logic                 busy
);

    localparam int              W          = 8 * WORDS;
    localparam int              IDXW       = idx_width(WORDS);
    localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(WORDS - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic [IDXW-1:0] r_idx;
    logic            r_last_grant;

    logic            w_grant_valid;
    logic            w_grant_id;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic            w_sel_sub;
    logic [7:0]      w_add_a;
    logic [7:0]      w_add_b;
    logic [7:0]      w_add_sum;
    logic            w_add_cout;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = c_REQ0;
        if (req0_valid && req1_valid) begin
            w_grant_valid = 1'b1;
            w_grant_id    = ~r_last_grant;
        end else if (req0_valid) begin
            w_grant_valid = 1'b1;
            w_grant_id    = c_REQ0;
        end else if (req1_valid) begin
            w_grant_valid = 1'b1;
            w_grant_id    = c_REQ1;
        end
    end

    assign w_sel_a   = (w_grant_id == c_REQ1) ? req1_a   : req0_a;
    assign w_sel_b   = (w_grant_id == c_REQ1) ? req1_b   : req0_b;
    assign w_sel_sub = (w_grant_id == c_REQ1) ? req1_sub : req0_sub;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_grant_valid)       w_next_state = c_RUN;
            c_RUN:   if (r_idx == c_LAST_IDX) w_next_state = c_DONE;
            c_DONE:  if (resp_ready)          w_next_state = c_IDLE;
            default:                          w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if ((r_state == c_IDLE) && w_grant_valid) begin
            req0_ready = (w_grant_id == c_REQ0);
            req1_ready = (w_grant_id == c_REQ1);
        end
        busy = (r_state == c_RUN) || (r_state == c_DONE);
    end

    assign w_add_a = r_a[{r_idx, 3'b000} +: 8];
    assign w_add_b = r_b[{r_idx, 3'b000} +: 8];

    carryselectadder8bit u_adder (
        .A    (w_add_a),
        .B    (w_add_b),
        .Cin  (r_carry),
        .Sum  (w_add_sum),
        .Cout (w_add_cout)
    );

    // Subtraction is A + ~B + 1: B is inverted at capture and the +1 seeds the carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_sum        <= '0;
            r_carry      <= 1'b0;
            r_idx        <= '0;
            r_last_grant <= c_REQ1;
            resp_valid   <= 1'b0;
            resp_id      <= 1'b0;
            resp_cout    <= 1'b0;
            resp_ovf     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_grant_valid) begin
                        r_a          <= w_sel_a;
                        r_b          <= w_sel_sub ? ~w_sel_b : w_sel_b;
                        r_carry      <= w_sel_sub;
                        r_idx        <= '0;
                        resp_id      <= w_grant_id;
                        r_last_grant <= w_grant_id;
                    end
                end
                c_RUN: begin
                    r_sum[{r_idx, 3'b000} +: 8] <= w_add_sum;
                    r_carry                     <= w_add_cout;
                    if (r_idx == c_LAST_IDX) begin
                        resp_cout  <= w_add_cout;
                        // Top sum bit comes straight from the adder since r_sum updates this edge.
                        resp_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_add_sum[7] != r_a[W-1]);
                        resp_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                c_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign resp_sum = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_adder8_serial_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder8_serial_scheduler
// Purpose  : Self-checking bench with a response scoreboard for the adder scheduler.
// Revision : 1.0
// ============================================================================
module tb_adder8_serial_scheduler;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_sub;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_sub;
    logic [W-1:0] req1_a, req1_b;
    logic         resp_valid, resp_ready, resp_id, resp_cout, resp_ovf, busy;
    logic [W-1:0] resp_sum;

    adder8_serial_scheduler #(.WORDS(WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_ovf   (resp_ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    logic         grants[$];
    int           total = 0;
    int           bad   = 0;
    int           cycle = 0;
    logic         prev_rv = 1'b0;
    logic         last_id, last_cout, last_ovf;
    logic [W-1:0] last_sum;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input int acc);
        exp_t       e;
        logic [W:0] full;
        if (sub) begin
            full   = {1'b0, a} - {1'b0, b};
            e.cout = ~full[W];
            e.ovf  = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        end else begin
            full   = {1'b0, a} + {1'b0, b};
            e.cout = full[W];
            e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        end
        e.id  = id;
        e.sum = full[W-1:0];
        e.acc = acc;
        return e;
    endfunction

    // Scoreboard: push on accept, check latency on rise, pop and compare on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_valid && req0_ready) begin
                sb.push_back(model(1'b0, req0_a, req0_b, req0_sub, cycle + 1));
                grants.push_back(1'b0);
            end
            if (req1_valid && req1_ready) begin
                sb.push_back(model(1'b1, req1_a, req1_b, req1_sub, cycle + 1));
                grants.push_back(1'b1);
            end
            total++;
            if (req0_ready && req1_ready) begin
                bad++;
                $display("FAIL ready_both: got r0=%b r1=%b want not both", req0_ready, req1_ready);
            end
            total++;
            if (busy && (req0_ready || req1_ready)) begin
                bad++;
                $display("FAIL ready_not_idle: got r0=%b r1=%b busy=1 want 0", req0_ready, req1_ready);
            end
            if (resp_valid && !prev_rv) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_resp: got resp_valid=1 want 0");
                end else if (cycle - sb[0].acc != WORDS) begin
                    bad++;
                    $display("FAIL latency: got %0d want %0d", cycle - sb[0].acc, WORDS);
                end
            end
            if (resp_valid && resp_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                total++;
                if ({resp_id, resp_sum, resp_cout, resp_ovf} !== {e.id, e.sum, e.cout, e.ovf}) begin
                    bad++;
                    $display("FAIL resp: got id=%b sum=%h cout=%b ovf=%b want id=%b sum=%h cout=%b ovf=%b",
                             resp_id, resp_sum, resp_cout, resp_ovf, e.id, e.sum, e.cout, e.ovf);
                end
                last_id   = resp_id;
                last_sum  = resp_sum;
                last_cout = resp_cout;
                last_ovf  = resp_ovf;
            end
            prev_rv = resp_valid;
        end
    end

    task automatic send(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        bit done = 0;
        if (id == 1'b0) begin
            req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
        end
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if ((id == 1'b0) ? req0_ready : req1_ready) done = 1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL accept_timeout: got no ready for req%0d want ready", id);
        end
        @(posedge clk); #1;
        if (id == 1'b0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sb.size() != 0 || busy) begin
            bad++;
            $display("FAIL drain_timeout: got pending=%0d busy=%b want 0 0", sb.size(), busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_result(input string name, input logic id, input logic [W-1:0] sum,
                                input logic cout, input logic ovf);
        total++;
        if ({last_id, last_sum, last_cout, last_ovf} !== {id, sum, cout, ovf}) begin
            bad++;
            $display("FAIL %s: got id=%b sum=%h cout=%b ovf=%b want id=%b sum=%h cout=%b ovf=%b",
                     name, last_id, last_sum, last_cout, last_ovf, id, sum, cout, ovf);
        end
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        grants.delete();
        prev_rv = 1'b0;
    endtask

    task automatic test_reset;
        req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        resp_ready = 1'b1;
        apply_reset();
        total++;
        if ({resp_valid, req0_ready, req1_ready, busy, resp_id, resp_cout, resp_ovf} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {resp_valid, req0_ready, req1_ready, busy, resp_id, resp_cout, resp_ovf});
        end
        total++;
        if (resp_sum !== '0) begin
            bad++;
            $display("FAIL reset_sum: got %h want 0", resp_sum);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_wrap;
        send(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        drain();
        check_result("add_wrap", 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    endtask

    task automatic test_sub_borrow;
        send(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1);
        drain();
        check_result("sub_borrow", 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    endtask

    task automatic test_overflow;
        send(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        drain();
        check_result("add_ovf", 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send(1'b0, 32'h8000_0000, 32'h0000_0001, 1'b1);
        drain();
        check_result("sub_ovf", 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    endtask

    task automatic test_round_robin;
        logic [3:0] order;
        apply_reset();
        rst = 1'b0;
        fork
            begin
                send(1'b0, 32'h1111_1111, 32'h2222_2222, 1'b0);
                send(1'b0, 32'h0000_0010, 32'h0000_0020, 1'b1);
            end
            begin
                send(1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0);
                send(1'b1, 32'hC000_0000, 32'hC000_0000, 1'b0);
            end
        join
        drain();
        order = 4'hF;
        if (grants.size() == 4) order = {grants[0], grants[1], grants[2], grants[3]};
        total++;
        if (grants.size() != 4 || order !== 4'b0101) begin
            bad++;
            $display("FAIL rr_order: got n=%0d order=%b want n=4 order=0101", grants.size(), order);
        end
        check_result("rr_last", 1'b1, 32'h8000_0000, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [W+1:0] held;
        int           gcount;
        int           n;
        resp_ready = 1'b0;
        grants.delete();
        send(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
        n = 0;
        while (!resp_valid && n < 50) begin @(negedge clk); n++; end
        total++;
        if (!resp_valid) begin
            bad++;
            $display("FAIL bp_resp_timeout: got resp_valid=0 want 1");
        end
        fork
            send(1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0);
            send(1'b1, 32'h0000_000A, 32'h0000_0003, 1'b1);
            begin
                @(negedge clk);
                held   = {resp_id, resp_sum, resp_cout};
                gcount = grants.size();
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    total++;
                    if ({resp_id, resp_sum, resp_cout} !== held || !resp_valid || grants.size() != gcount) begin
                        bad++;
                        $display("FAIL bp_hold: got id/sum/cout=%h v=%b grants=%0d want %h v=1 grants=%0d",
                                 {resp_id, resp_sum, resp_cout}, resp_valid, grants.size(), held, gcount);
                    end
                end
                total++;
                if (resp_sum !== 32'h2345_6789) begin
                    bad++;
                    $display("FAIL bp_sum: got %h want 23456789", resp_sum);
                end
                @(posedge clk); #1;
                resp_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                total++;
                if ({busy, req0_ready, req1_ready} !== 3'b001) begin
                    bad++;
                    $display("FAIL bp_release: got busy/r0/r1=%b want 001", {busy, req0_ready, req1_ready});
                end
            end
        join
        drain();
        total++;
        if (grants.size() != 3 || grants[1] !== 1'b1 || grants[2] !== 1'b0) begin
            bad++;
            $display("FAIL bp_order: got n=%0d want n=3 order 0,1,0", grants.size());
        end
    endtask

    task automatic test_reset_midrun;
        send(1'b0, 32'h0102_0304, 32'h1020_3040, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({resp_valid, req0_ready, req1_ready, busy, resp_id, resp_cout, resp_ovf} !== 7'b0
            || resp_sum !== '0) begin
            bad++;
            $display("FAIL midrun_reset: got ctrl=%b sum=%h want 0 0",
                     {resp_valid, req0_ready, req1_ready, busy, resp_id, resp_cout, resp_ovf}, resp_sum);
        end
        sb.delete();
        prev_rv = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(1'b1, 32'hDEAD_BEEF, 32'h0000_0001, 1'b1);
        drain();
        check_result("after_reset", 1'b1, 32'hDEAD_BEEE, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        test_reset();
        test_add_wrap();
        test_sub_borrow();
        test_overflow();
        test_round_robin();
        test_back_to_back();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
